det_seq: RTL

DET_SEQ -- requirements
Module: det_seq

---
 rtl/det_seq.sv | 83 ++++++++
 1 files changed

// File: rtl/det_seq.sv
// Serial pattern detector with a run-time loadable pattern/length, overlap
// selection and a saturating match counter.
module det_seq #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter bit                 OVERLAP     = 1'b1,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1011),
  parameter int                 DEF_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         clr_cnt,
  output logic                         out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         armed
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);
  localparam logic [LW-1:0] RST_LEN = (DEF_LEN > MAX_LEN) ? LW'(MAX_LEN) : LW'(DEF_LEN);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      fill;
  logic [LW-1:0]      len;

  logic [MAX_LEN:0]   window;
  logic [MAX_LEN:0]   mask;
  logic               enough;
  logic               hit;
  logic [LW-1:0]      load_len;

  // The window is one bit wider than history so a full-length pattern can be
  // compared against the history plus the bit currently arriving.
  always_comb begin
    window   = {history, in};
    mask     = ~({(MAX_LEN+1){1'b1}} << len);
    enough   = ((LW+1)'(fill) + (LW+1)'(1)) >= (LW+1)'(len);
    hit      = in_valid && !cfg_load && (len != '0) && enough &&
               (((window ^ {1'b0, pattern}) & mask) == '0);
    load_len = (cfg_len > MAX_L) ? MAX_L : cfg_len;
  end

  assign armed = (len != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      history   <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
      pattern   <= DEF_PATTERN;
      len       <= RST_LEN;
    end else begin
      out <= hit;

      // A config load wins over a same-cycle bit, which is simply dropped.
      if (cfg_load) begin
        pattern <= cfg_pattern;
        len     <= load_len;
        history <= '0;
        fill    <= '0;
      end else if (in_valid) begin
        history <= window[MAX_LEN-1:0];
        if (hit && !OVERLAP)
          fill <= '0;
        else if (fill != MAX_L)
          fill <= fill + LW'(1);
      end

      if (clr_cnt)
        match_cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule
